sort4_ctrl: RTL and testbench

Sequencing controller that sorts four 4-bit operands using a single shared 4-bit magnitude comparator, one compare/swap per clock. It accepts a packed word on a start strobe and walks a fixed 6-step bubble-sort schedule. It returns the sorted word, a swap count and a one-cycle done pulse. It sits in front of the comparator datapath and is the only block that drives its operand inputs.

---
 rtl/sort4_pkg.sv | 29 ++
 rtl/sort4_ctrl_mag_cmp4.sv | 16 +
 rtl/sort4_ctrl.sv | 107 ++++++++++
 tb/tb_sort4_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sort4_pkg.sv
// rtl/sort4_pkg.sv - shared types, constants and element helpers for the 4-operand sorter
package sort4_pkg;

  localparam int DW    = 4;
  localparam int N     = 4;
  localparam int STEPS = 6;

  // Pair index per step, step 0 in the LSBs: 0, 1, 2, 0, 1, 0
  localparam logic [2*STEPS-1:0] SCHED = {2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_e;

  function automatic logic [DW-1:0] elem_get(input logic [N*DW-1:0] w, input logic [1:0] i);
    return w[i*DW +: DW];
  endfunction

  function automatic logic [N*DW-1:0] elem_set(input logic [N*DW-1:0] w, input logic [1:0] i,
                                               input logic [DW-1:0] v);
    logic [N*DW-1:0] r;
    r = w;
    r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [1:0] sched_pair(input logic [2:0] step);
    return SCHED[step*2 +: 2];
  endfunction

endpackage

// File: rtl/sort4_ctrl_mag_cmp4.sv
// rtl/sort4_ctrl_mag_cmp4.sv - combinational 4-bit magnitude comparator
module mag_cmp4
  import sort4_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          eq,
  output logic          gt,
  output logic          lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/sort4_ctrl.sv
// rtl/sort4_ctrl.sv - sorts four 4-bit operands with one shared comparator, one compare/swap per clock
module sort4_ctrl
  import sort4_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            descend_i,
  input  logic [N*DW-1:0] data_in_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [N*DW-1:0] data_out_o,
  output logic [2:0]      swaps_o
);

  state_e          state_q, state_d;
  logic [2:0]      step_q, step_d;
  logic            desc_q, desc_d;
  logic [2:0]      swaps_q, swaps_d;
  logic [N*DW-1:0] data_q, data_d;

  logic [1:0]    k, k1;
  logic [DW-1:0] op_a, op_b;
  logic          cmp_eq, cmp_gt, cmp_lt;
  logic          do_swap;

  assign k    = sched_pair(step_q);
  assign k1   = k + 2'd1;
  assign op_a = elem_get(data_q, k);
  assign op_b = elem_get(data_q, k1);

  mag_cmp4 u_cmp (
    .a  (op_a),
    .b  (op_b),
    .eq (cmp_eq),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  // Equal operands never move, which keeps the sort stable
  assign do_swap = ~cmp_eq & (desc_q ? cmp_lt : cmp_gt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SORT;
      SORT:    if (step_q == 3'(STEPS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE);
    busy_o  = (state_q == SORT);
    done_o  = (state_q == DONE);
  end

  always_comb begin
    data_d  = data_q;
    desc_d  = desc_q;
    swaps_d = swaps_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          data_d  = data_in_i;
          desc_d  = descend_i;
          swaps_d = '0;
          step_d  = '0;
        end
      end
      SORT: begin
        step_d = step_q + 3'd1;
        if (do_swap) begin
          data_d  = elem_set(elem_set(data_q, k, op_b), k1, op_a);
          swaps_d = swaps_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      desc_q  <= 1'b0;
      swaps_q <= '0;
      step_q  <= '0;
    end else begin
      data_q  <= data_d;
      desc_q  <= desc_d;
      swaps_q <= swaps_d;
      step_q  <= step_d;
    end
  end

  assign data_out_o = data_q;
  assign swaps_o    = swaps_q;

endmodule

// File: tb/tb_sort4_ctrl.sv
// tb/tb_sort4_ctrl.sv - self-checking bench for sort4_ctrl against a rank/inversion reference model
module tb_sort4_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        descend_i;
  logic [15:0] data_in_i;
  logic        ready_o, busy_o, done_o;
  logic [15:0] data_out_o;
  logic [2:0]  swaps_o;

  int vectors    = 0;
  int miscompares = 0;

  sort4_ctrl dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .descend_i  (descend_i),
    .data_in_i  (data_in_i),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .data_out_o (data_out_o),
    .swaps_o    (swaps_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stable sort by rank; a full bubble schedule swaps exactly once per inverted pair
  function automatic void model(input logic [15:0] w, input logic desc,
                                output logic [15:0] res, output int sw);
    int e[4];
    int pos;
    for (int i = 0; i < 4; i++) e[i] = int'(w[4*i +: 4]);
    res = '0;
    sw  = 0;
    for (int i = 0; i < 4; i++) begin
      pos = 0;
      for (int j = 0; j < 4; j++) begin
        if ((desc ? (e[j] > e[i]) : (e[j] < e[i])) || (e[j] == e[i] && j < i)) pos++;
        if (i < j && (desc ? (e[j] > e[i]) : (e[j] < e[i]))) sw++;
      end
      res[4*pos +: 4] = 4'(e[i]);
    end
  endfunction

  task automatic run_sort(input logic [15:0] w, input logic desc, input bit inj);
    logic [15:0] exp_d;
    int exp_s;
    int lat;
    int busy_n;
    model(w, desc, exp_d, exp_s);
    @(negedge clk_i);
    check("ready_idle", 32'(ready_o), 32'd1);
    start_i   = 1'b1;
    data_in_i = w;
    descend_i = desc;
    lat = 0;
    busy_n = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk_i);
      start_i   = inj && (cyc == 2 || cyc == 7);
      data_in_i = 16'($urandom);
      descend_i = 1'($urandom);
      if (busy_o) busy_n++;
      if (busy_o && done_o) check("busy_done_overlap", 32'd1, 32'd0);
      if (done_o) begin
        lat = cyc;
        break;
      end
    end
    check("latency", 32'(lat), 32'd7);
    check("busy_cycles", 32'(busy_n), 32'd6);
    check("data_out", 32'(data_out_o), 32'(exp_d));
    check("swaps", 32'(swaps_o), 32'(exp_s));
    @(negedge clk_i);
    start_i = 1'b0;
    check("done_one_cycle", 32'(done_o), 32'd0);
    check("ready_back", 32'(ready_o), 32'd1);
    check("data_hold", 32'(data_out_o), 32'(exp_d));
  endtask

  initial begin
    logic [15:0] exp_d;
    int exp_s;
    int last;
    int n;
    logic [15:0] w;

    rst_i = 1'b1; start_i = 1'b0; descend_i = 1'b0; data_in_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_data", 32'(data_out_o), 32'd0);
    check("rst_swaps", 32'(swaps_o), 32'd0);
    rst_i = 1'b0;

    run_sort(16'h0213, 1'b0, 1'b0);
    run_sort(16'h3210, 1'b0, 1'b0);
    run_sort(16'h05AF, 1'b0, 1'b0);
    run_sort(16'h3210, 1'b1, 1'b0);
    run_sort(16'h7777, 1'b0, 1'b0);
    run_sort(16'h7577, 1'b0, 1'b0);
    run_sort(16'h0213, 1'b0, 1'b1);
    run_sort(16'h9C4E, 1'b1, 1'b1);

    // start held high: one accepted request every 8 cycles
    model(16'h0213, 1'b0, exp_d, exp_s);
    @(negedge clk_i);
    start_i = 1'b1; data_in_i = 16'h0213; descend_i = 1'b0;
    last = -1; n = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk_i);
      if (done_o) begin
        check("held_data", 32'(data_out_o), 32'(exp_d));
        if (last >= 0) check("held_gap", 32'(cyc - last), 32'd8);
        last = cyc;
        n++;
      end
    end
    start_i = 1'b0;
    check("held_count", 32'(n), 32'd5);
    repeat (10) @(negedge clk_i);

    // reset in the third cycle of SORT
    start_i = 1'b1; data_in_i = 16'h05AF; descend_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_data", 32'(data_out_o), 32'd0);
    check("midrst_swaps", 32'(swaps_o), 32'd0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk_i);
      check("midrst_no_done", 32'(done_o), 32'd0);
    end
    rst_i = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk_i);
      check("postrst_idle_no_done", 32'(done_o), 32'd0);
    end
    run_sort(16'h05AF, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      if (t % 2 == 0) w = 16'($urandom);
      else for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(0, 3));
      run_sort(w, 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
